// File: rtl/video_out_stage.sv
// Output stage for the VGA DAC: registers the 5-6-5 pixel bus, delays and polarises the syncs, and monitors incoming timing.
// Latency: pixels 1 clock; syncs SYNC_DELAY+1 clocks; monitor outputs update 1 clock after the triggering sync edge.
// Backpressure: none; the block accepts one pixel per clock unconditionally.
module video_out_stage #(
    parameter int unsigned SYNC_DELAY  = 2,
    parameter bit          HSYNC_POL   = 1'b1,
    parameter bit          VSYNC_POL   = 1'b1,
    parameter logic [11:0] EXP_H_TOTAL = 12'd1689,
    parameter logic [11:0] EXP_V_TOTAL = 12'd1067
) (
    input  logic        pixel_clock,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [4:0]  r_in,
    input  logic [5:0]  g_in,
    input  logic [4:0]  b_in,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [4:0]  r_out,
    output logic [5:0]  g_out,
    output logic [4:0]  b_out,
    output logic [11:0] h_total,
    output logic [11:0] v_total,
    output logic [15:0] frame_count,
    output logic        timing_lock
);

    localparam logic [11:0] CNT_MAX = 12'hFFF;

    logic [SYNC_DELAY:0] hs_sr_q, hs_sr_d;
    logic [SYNC_DELAY:0] vs_sr_q, vs_sr_d;
    logic [4:0]          r_q, r_d;
    logic [5:0]          g_q, g_d;
    logic [4:0]          b_q, b_d;
    logic                hsync_prev_q, hsync_prev_d;
    logic                vsync_prev_q, vsync_prev_d;
    logic [11:0]         h_cnt_q, h_cnt_d;
    logic [11:0]         v_cnt_q, v_cnt_d;
    logic [11:0]         h_total_q, h_total_d;
    logic [11:0]         v_total_q, v_total_d;
    logic [15:0]         frame_count_q, frame_count_d;
    logic                h_seen_q, h_seen_d;
    logic                v_seen_q, v_seen_d;
    logic                h_ok_frame_q, h_ok_frame_d;
    logic                lock_q, lock_d;

    logic                hrise;
    logic                vrise;
    logic                h_timeout;
    logic                h_mis;
    logic [11:0]         v_new;

    // Next-state for pixel/sync pipelines and the timing monitor.
    always_comb begin
        r_d           = r_in;
        g_d           = g_in;
        b_d           = b_in;
        hsync_prev_d  = hsync_in;
        vsync_prev_d  = vsync_in;
        hs_sr_d       = hs_sr_q;
        vs_sr_d       = vs_sr_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        h_total_d     = h_total_q;
        v_total_d     = v_total_q;
        frame_count_d = frame_count_q;
        h_seen_d      = h_seen_q;
        v_seen_d      = v_seen_q;
        h_ok_frame_d  = h_ok_frame_q;
        lock_d        = lock_q;

        // Sync delay line: stage 0 takes the input, stage SYNC_DELAY drives the pins.
        hs_sr_d[0] = hsync_in;
        vs_sr_d[0] = vsync_in;
        for (int i = 1; i <= int'(SYNC_DELAY); i++) begin
            hs_sr_d[i] = hs_sr_q[i-1];
            vs_sr_d[i] = vs_sr_q[i-1];
        end

        hrise     = hsync_in & ~hsync_prev_q;
        vrise     = vsync_in & ~vsync_prev_q;
        // A rising hsync on the saturation cycle is a real (if long) line, not a timeout.
        h_timeout = (h_cnt_q == CNT_MAX) & ~hrise;
        h_mis     = hrise & h_seen_q & (h_cnt_q != EXP_H_TOTAL);
        // An hrise coincident with vrise still closes the ending frame.
        v_new     = v_cnt_q + {11'd0, hrise};

        // Horizontal period measurement; first edge after reset/timeout only arms.
        if (hrise) begin
            if (h_seen_q) begin
                h_total_d = h_cnt_q;
            end
            h_seen_d = 1'b1;
            h_cnt_d  = 12'd1;
        end else begin
            if (h_cnt_q != CNT_MAX) begin
                h_cnt_d = h_cnt_q + 12'd1;
            end
            if (h_timeout) begin
                h_seen_d = 1'b0;
            end
        end

        // Vertical period measurement in lines, plus frame counter.
        if (vrise) begin
            if (v_seen_q) begin
                v_total_d = v_new;
            end
            v_cnt_d       = 12'd0;
            v_seen_d      = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
        end else if (hrise && (v_cnt_q != CNT_MAX)) begin
            v_cnt_d = v_cnt_q + 12'd1;
        end

        // Lock: set at frame boundary if the whole frame was clean; a bad line or lost hsync wins.
        if (vrise) begin
            h_ok_frame_d = 1'b1;
        end
        if (vrise && v_seen_q) begin
            lock_d = h_ok_frame_q & (v_new == EXP_V_TOTAL) & ~h_mis;
        end
        if (h_mis || h_timeout) begin
            h_ok_frame_d = 1'b0;
            lock_d       = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            hs_sr_q       <= '0;
            vs_sr_q       <= '0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            hsync_prev_q  <= 1'b0;
            vsync_prev_q  <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            frame_count_q <= '0;
            h_seen_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            h_ok_frame_q  <= 1'b0;
            lock_q        <= 1'b0;
        end else begin
            hs_sr_q       <= hs_sr_d;
            vs_sr_q       <= vs_sr_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            hsync_prev_q  <= hsync_prev_d;
            vsync_prev_q  <= vsync_prev_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            h_total_q     <= h_total_d;
            v_total_q     <= v_total_d;
            frame_count_q <= frame_count_d;
            h_seen_q      <= h_seen_d;
            v_seen_q      <= v_seen_d;
            h_ok_frame_q  <= h_ok_frame_d;
            lock_q        <= lock_d;
        end
    end

    assign hsync_out   = hs_sr_q[SYNC_DELAY] ~^ HSYNC_POL;
    assign vsync_out   = vs_sr_q[SYNC_DELAY] ~^ VSYNC_POL;
    assign r_out       = r_q;
    assign g_out       = g_q;
    assign b_out       = b_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign frame_count = frame_count_q;
    assign timing_lock = lock_q;

endmodule
